// File: rtl/nec_bus_pkg.sv
// Shared types for the NEC V30/V33 bus slave.
//   state_t      : bus-cycle FSM states
//   trace_kind_t : cycle class stored in trace bits [63:62]
//   trace_rec_t  : 64-bit trace record layout
//   TRACE_W      : trace record width
package nec_bus_pkg;

   localparam int unsigned TRACE_W = 64;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_STROBE,
      ST_WCAP,
      ST_MEM,
      ST_INTA,
      ST_HOLD
   } state_t;

   typedef enum logic [1:0] {
      TK_MEM_RD = 2'd0,
      TK_MEM_WR = 2'd1,
      TK_IO_RD  = 2'd2,
      TK_IO_WR  = 2'd3
   } trace_kind_t;

   typedef struct packed {
      trace_kind_t kind;     // [63:62]
      logic        inta;     // [61]
      logic        timeout;  // [60]
      logic [19:0] addr;     // [59:40]
      logic [1:0]  be;       // [39:38]
      logic [5:0]  rsvd;     // [37:32]
      logic [15:0] data;     // [31:16]
      logic [15:0] ts;       // [15:0]
   } trace_rec_t;

   function automatic trace_kind_t kind_of(input logic io, input logic we);
      return trace_kind_t'({io, we});
   endfunction

endpackage

// File: rtl/nec_pin_sync.sv
// Multi-flop synchronizer with falling-edge detect on the synchronized copy.
//   clk, reset : core clock, synchronous active-high reset
//   d_i        : raw asynchronous input(s)
//   q_o        : synchronized level
//   fall_o     : one-cycle pulse per bit when q_o goes 1 -> 0
module nec_pin_sync #(
   parameter int unsigned      WIDTH   = 1,
   parameter int unsigned      STAGES  = 2,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o,
   output logic [WIDTH-1:0] fall_o
);

   logic [WIDTH-1:0] stage_q [STAGES];
   logic [WIDTH-1:0] prev_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < STAGES; i++) stage_q[i] <= RST_VAL;
         prev_q <= RST_VAL;
      end else begin
         stage_q[0] <= d_i;
         for (int unsigned i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
         prev_q <= stage_q[STAGES-1];
      end
   end

   assign q_o    = stage_q[STAGES-1];
   assign fall_o = prev_q & ~q_o;

endmodule

// File: rtl/nec_bus_slave.sv
// NEC V30/V33 bus-cycle decoder: turns each memory / I/O / INTA cycle into one
// memory-side request, paces the CPU with READY, drives read data onto AD and
// emits one 64-bit trace record per completed cycle.
//   clk, reset                 : core clock, synchronous active-high reset
//   nec_ad_in                  : AD[19:0] from pins
//   nec_ad_out, nec_ad_oe      : AD[15:0] drive data and output enable
//   nec_ready                  : CPU READY (1 = cycle may complete)
//   nec_astb..nec_intakn       : raw CPU strobes
//   mem_req/ack/addr/we/io/be/wdata/rdata : memory arbiter request port
//   trace_valid/ready/data     : single-register trace output
//   trace_overflow, timeout_err: sticky error flags
module nec_bus_slave
   import nec_bus_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT     = 255,
   parameter logic [7:0]  INTA_VECTOR = 8'h08
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [19:0]        nec_ad_in,
   output logic [15:0]        nec_ad_out,
   output logic               nec_ad_oe,
   output logic               nec_ready,
   input  logic               nec_astb,
   input  logic               nec_rdn,
   input  logic               nec_wrn,
   input  logic               nec_ion,
   input  logic               nec_ubenn,
   input  logic               nec_intakn,
   output logic               mem_req,
   input  logic               mem_ack,
   output logic [19:0]        mem_addr,
   output logic               mem_we,
   output logic               mem_io,
   output logic [1:0]         mem_be,
   output logic [15:0]        mem_wdata,
   input  logic [15:0]        mem_rdata,
   output logic               trace_valid,
   input  logic               trace_ready,
   output logic [TRACE_W-1:0] trace_data,
   output logic               trace_overflow,
   output logic               timeout_err
);

   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   // Synchronized pins
   logic        astb_s, astb_f, rdn_s, rdn_f, wrn_s, wrn_f;
   logic        ion_s, ion_f, ubenn_s, ubenn_f, intak_s, intak_f;
   logic [19:0] ad_s, ad_f;

   nec_pin_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_astb (
      .clk(clk), .reset(reset), .d_i(nec_astb), .q_o(astb_s), .fall_o(astb_f));
   nec_pin_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_rdn (
      .clk(clk), .reset(reset), .d_i(nec_rdn), .q_o(rdn_s), .fall_o(rdn_f));
   nec_pin_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_wrn (
      .clk(clk), .reset(reset), .d_i(nec_wrn), .q_o(wrn_s), .fall_o(wrn_f));
   nec_pin_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ion (
      .clk(clk), .reset(reset), .d_i(nec_ion), .q_o(ion_s), .fall_o(ion_f));
   nec_pin_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ubenn (
      .clk(clk), .reset(reset), .d_i(nec_ubenn), .q_o(ubenn_s), .fall_o(ubenn_f));
   nec_pin_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_intakn (
      .clk(clk), .reset(reset), .d_i(nec_intakn), .q_o(intak_s), .fall_o(intak_f));
   nec_pin_sync #(.WIDTH(20), .STAGES(SYNC_STAGES), .RST_VAL(20'h0)) u_sync_ad (
      .clk(clk), .reset(reset), .d_i(nec_ad_in), .q_o(ad_s), .fall_o(ad_f));

   // Levels are used for these; their edge outputs are not needed.
   logic unused_sync;
   assign unused_sync = ^{astb_s, rdn_f, wrn_f, ion_f, ubenn_f, ad_f};

   // State
   state_t        state_q, state_d;
   logic [19:0]   addr_q, addr_d;
   logic [1:0]    be_q, be_d;
   logic          io_q, io_d, we_q, we_d, req_q, req_d;
   logic [15:0]   wdata_q, wdata_d, ad_out_q, ad_out_d;
   logic          oe_q, oe_d, ready_q, ready_d;
   logic          inta_q, inta_d, tout_q, tout_d, tmo_err_q, tmo_err_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0]   ts_q, ts_d, ts_cap_q, ts_cap_d;
   trace_rec_t    tr_q, tr_d;
   logic          tr_valid_q, tr_valid_d, ovf_q, ovf_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         be_q       <= '0;
         io_q       <= 1'b0;
         we_q       <= 1'b0;
         req_q      <= 1'b0;
         wdata_q    <= '0;
         ad_out_q   <= '0;
         oe_q       <= 1'b0;
         ready_q    <= 1'b1;
         inta_q     <= 1'b0;
         tout_q     <= 1'b0;
         tmo_err_q  <= 1'b0;
         cnt_q      <= '0;
         ts_q       <= '0;
         ts_cap_q   <= '0;
         tr_q       <= '0;
         tr_valid_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         be_q       <= be_d;
         io_q       <= io_d;
         we_q       <= we_d;
         req_q      <= req_d;
         wdata_q    <= wdata_d;
         ad_out_q   <= ad_out_d;
         oe_q       <= oe_d;
         ready_q    <= ready_d;
         inta_q     <= inta_d;
         tout_q     <= tout_d;
         tmo_err_q  <= tmo_err_d;
         cnt_q      <= cnt_d;
         ts_q       <= ts_d;
         ts_cap_q   <= ts_cap_d;
         tr_q       <= tr_d;
         tr_valid_q <= tr_valid_d;
         ovf_q      <= ovf_d;
      end
   end

   always_comb begin
      trace_rec_t rec;
      logic       push;

      state_d    = state_q;
      addr_d     = addr_q;
      be_d       = be_q;
      io_d       = io_q;
      we_d       = we_q;
      req_d      = req_q;
      wdata_d    = wdata_q;
      ad_out_d   = ad_out_q;
      oe_d       = oe_q;
      ready_d    = ready_q;
      inta_d     = inta_q;
      tout_d     = tout_q;
      tmo_err_d  = tmo_err_q;
      cnt_d      = cnt_q;
      ts_d       = ts_q + 16'd1;
      ts_cap_d   = ts_cap_q;
      tr_d       = tr_q;
      tr_valid_d = tr_valid_q;
      ovf_d      = ovf_q;
      push       = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (astb_f) begin
               addr_d   = ad_s;
               be_d     = {~ubenn_s, ~ad_s[0]};
               io_d     = ~ion_s;
               we_d     = 1'b0;
               inta_d   = 1'b0;
               tout_d   = 1'b0;
               ts_cap_d = ts_q;
               ready_d  = 1'b0;
               state_d  = ST_STROBE;
            end else if (intak_f) begin
               addr_d   = '0;
               be_d     = '0;
               io_d     = 1'b0;
               we_d     = 1'b0;
               inta_d   = 1'b1;
               tout_d   = 1'b0;
               ts_cap_d = ts_q;
               state_d  = ST_INTA;
            end
         end
         ST_STROBE: begin
            if (!rdn_s) begin
               req_d   = 1'b1;
               we_d    = 1'b0;
               cnt_d   = '0;
               state_d = ST_MEM;
            end else if (!wrn_s) begin
               // Write data is taken one cycle after WRn is seen low.
               state_d = ST_WCAP;
            end
         end
         ST_WCAP: begin
            wdata_d = ad_s[15:0];
            we_d    = 1'b1;
            req_d   = 1'b1;
            cnt_d   = '0;
            state_d = ST_MEM;
         end
         ST_MEM: begin
            // A completing ack wins over a coincident timeout.
            if (mem_ack) begin
               req_d   = 1'b0;
               ready_d = 1'b1;
               if (!we_q) begin
                  ad_out_d = mem_rdata;
                  oe_d     = 1'b1;
               end
               state_d = ST_HOLD;
            end else if (cnt_q == CNT_LAST) begin
               req_d     = 1'b0;
               ready_d   = 1'b1;
               tout_d    = 1'b1;
               tmo_err_d = 1'b1;
               if (!we_q) begin
                  ad_out_d = 16'hFFFF;
                  oe_d     = 1'b1;
               end
               state_d = ST_HOLD;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_INTA: begin
            ad_out_d = {8'h00, INTA_VECTOR};
            oe_d     = 1'b1;
            ready_d  = 1'b1;
            state_d  = ST_HOLD;
         end
         ST_HOLD: begin
            if (rdn_s && wrn_s && intak_s) begin
               oe_d    = 1'b0;
               push    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Record data is the write data for writes, otherwise whatever was
      // driven onto AD (read data, 16'hFFFF on timeout, or the INTA vector).
      rec.kind    = kind_of(io_q, we_q);
      rec.inta    = inta_q;
      rec.timeout = tout_q;
      rec.addr    = addr_q;
      rec.be      = be_q;
      rec.rsvd    = '0;
      rec.data    = we_q ? wdata_q : ad_out_q;
      rec.ts      = ts_cap_q;

      if (push) begin
         if (tr_valid_q && !trace_ready) begin
            ovf_d = 1'b1;
         end else begin
            tr_d       = rec;
            tr_valid_d = 1'b1;
         end
      end else if (tr_valid_q && trace_ready) begin
         tr_valid_d = 1'b0;
      end
   end

   assign nec_ad_out     = ad_out_q;
   assign nec_ad_oe      = oe_q;
   assign nec_ready      = ready_q;
   assign mem_req        = req_q;
   assign mem_addr       = addr_q;
   assign mem_we         = we_q;
   assign mem_io         = io_q;
   assign mem_be         = be_q;
   assign mem_wdata      = wdata_q;
   assign trace_valid    = tr_valid_q;
   assign trace_data     = tr_q;
   assign trace_overflow = ovf_q;
   assign timeout_err    = tmo_err_q;

endmodule

// File: tb/tb_nec_bus_slave.sv
// Directed self-checking bench for nec_bus_slave.
module tb_nec_bus_slave;

   logic        clk = 1'b0;
   logic        reset;
   logic [19:0] nec_ad_in;
   logic [15:0] nec_ad_out;
   logic        nec_ad_oe, nec_ready;
   logic        nec_astb, nec_rdn, nec_wrn, nec_ion, nec_ubenn, nec_intakn;
   logic        mem_req, mem_ack;
   logic [19:0] mem_addr;
   logic        mem_we, mem_io;
   logic [1:0]  mem_be;
   logic [15:0] mem_wdata, mem_rdata;
   logic        trace_valid, trace_ready;
   logic [63:0] trace_data;
   logic        trace_overflow, timeout_err;

   int          tests_run = 0;
   int          failed    = 0;
   int          cyc       = 0;
   logic [15:0] ts_exp, ts_first;
   logic        saw_req;

   always #5 clk = ~clk;

   nec_bus_slave #(
      .SYNC_STAGES(2),
      .TIMEOUT(255),
      .INTA_VECTOR(8'h08)
   ) dut (
      .clk(clk), .reset(reset),
      .nec_ad_in(nec_ad_in), .nec_ad_out(nec_ad_out), .nec_ad_oe(nec_ad_oe),
      .nec_ready(nec_ready),
      .nec_astb(nec_astb), .nec_rdn(nec_rdn), .nec_wrn(nec_wrn),
      .nec_ion(nec_ion), .nec_ubenn(nec_ubenn), .nec_intakn(nec_intakn),
      .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr),
      .mem_we(mem_we), .mem_io(mem_io), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .trace_valid(trace_valid), .trace_ready(trace_ready),
      .trace_data(trace_data), .trace_overflow(trace_overflow),
      .timeout_err(timeout_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_req();
      for (int i = 0; i < 16 && mem_req !== 1'b1; i++) tick();
      check("mem_req_seen", mem_req, 1'b1);
   endtask

   task automatic wait_oe_low();
      for (int i = 0; i < 16 && nec_ad_oe !== 1'b0; i++) tick();
      check("oe_released", nec_ad_oe, 1'b0);
   endtask

   // Address phase; ts_exp is the timestamp the DUT captured on the edge
   // that dropped READY (counter value before that edge).
   task automatic astb_phase(input logic [19:0] a, input logic io_n, input logic ube_n);
      nec_ad_in = a;
      nec_ion   = io_n;
      nec_ubenn = ube_n;
      nec_astb  = 1'b1;
      tick();
      tick();
      nec_astb = 1'b0;
      for (int i = 0; i < 8 && nec_ready !== 1'b0; i++) tick();
      check("ready_low_after_astb", nec_ready, 1'b0);
      ts_exp = 16'(cyc - 1);
   endtask

   task automatic do_read(input logic [19:0] a, input logic io_n, input logic ube_n,
                          input logic [15:0] rd, input int delay);
      astb_phase(a, io_n, ube_n);
      nec_rdn = 1'b0;
      wait_req();
      repeat (delay) tick();
      mem_rdata = rd;
      mem_ack   = 1'b1;
      tick();
      mem_ack = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests run %0d", tests_run);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      nec_ad_in = '0; nec_astb = 1'b0; nec_rdn = 1'b1; nec_wrn = 1'b1;
      nec_ion = 1'b1; nec_ubenn = 1'b1; nec_intakn = 1'b1;
      mem_ack = 1'b0; mem_rdata = '0; trace_ready = 1'b1;
      repeat (3) tick();

      // Reset state
      check("rst_oe",     nec_ad_oe, 1'b0);
      check("rst_adout",  nec_ad_out, 16'h0000);
      check("rst_ready",  nec_ready, 1'b1);
      check("rst_req",    mem_req, 1'b0);
      check("rst_tvalid", trace_valid, 1'b0);
      check("rst_ovf",    trace_overflow, 1'b0);
      check("rst_tmo",    timeout_err, 1'b0);
      reset = 1'b0;
      cyc   = 0;
      repeat (2) tick();

      // Memory read 0x12344, UBEn=0, ack on 5th clock
      astb_phase(20'h12344, 1'b1, 1'b0);
      nec_rdn = 1'b0;
      wait_req();
      check("rd_addr", mem_addr, 20'h12344);
      check("rd_we",   mem_we, 1'b0);
      check("rd_io",   mem_io, 1'b0);
      check("rd_be",   mem_be, 2'b11);
      repeat (4) tick();
      check("rd_ready_wait", nec_ready, 1'b0);
      check("rd_req_held",   mem_req, 1'b1);
      mem_rdata = 16'hBEEF;
      mem_ack   = 1'b1;
      check("rd_ready_at_ack", nec_ready, 1'b0);
      tick();
      mem_ack = 1'b0;
      check("rd_ready_after_ack", nec_ready, 1'b1);
      check("rd_req_drop", mem_req, 1'b0);
      check("rd_oe",       nec_ad_oe, 1'b1);
      check("rd_adout",    nec_ad_out, 16'hBEEF);
      repeat (2) tick();
      check("rd_ad_hold", {nec_ad_oe, nec_ad_out}, {1'b1, 16'hBEEF});
      nec_rdn = 1'b1;
      wait_oe_low();
      check("rd_tvalid", trace_valid, 1'b1);
      check("rd_trace", trace_data,
            {2'd0, 1'b0, 1'b0, 20'h12344, 2'b11, 6'd0, 16'hBEEF, ts_exp});

      // I/O write, odd address 0x00081, UBEn=0, data on upper lane
      astb_phase(20'h00081, 1'b0, 1'b0);
      nec_ad_in = 20'h05A00;
      nec_wrn   = 1'b0;
      wait_req();
      check("wr_addr",  mem_addr, 20'h00081);
      check("wr_we",    mem_we, 1'b1);
      check("wr_io",    mem_io, 1'b1);
      check("wr_be",    mem_be, 2'b10);
      check("wr_wdata", mem_wdata, 16'h5A00);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      check("wr_ready", nec_ready, 1'b1);
      check("wr_req_drop", mem_req, 1'b0);
      check("wr_no_oe", nec_ad_oe, 1'b0);
      nec_wrn = 1'b1;
      for (int i = 0; i < 16 && trace_valid !== 1'b1; i++) tick();
      check("wr_trace", trace_data,
            {2'd3, 1'b0, 1'b0, 20'h00081, 2'b10, 6'd0, 16'h5A00, ts_exp});

      // INTA cycle
      tick();
      nec_intakn = 1'b0;
      saw_req    = 1'b0;
      for (int i = 0; i < 16 && nec_ad_oe !== 1'b1; i++) begin
         tick();
         if (mem_req === 1'b1) saw_req = 1'b1;
      end
      check("inta_oe",     nec_ad_oe, 1'b1);
      check("inta_vector", nec_ad_out, 16'h0008);
      check("inta_ready",  nec_ready, 1'b1);
      check("inta_no_req", saw_req, 1'b0);
      nec_intakn = 1'b1;
      wait_oe_low();
      check("inta_tvalid",  trace_valid, 1'b1);
      check("inta_flag",    trace_data[61], 1'b1);
      check("inta_tdata",   trace_data[31:16], 16'h0008);

      // Timeout: read 0x00100, UBEn=1, no ack
      astb_phase(20'h00100, 1'b1, 1'b1);
      nec_rdn = 1'b0;
      wait_req();
      repeat (254) tick();
      check("tmo_req_254",  mem_req, 1'b1);
      check("tmo_flag_254", timeout_err, 1'b0);
      tick();
      check("tmo_flag",  timeout_err, 1'b1);
      check("tmo_req",   mem_req, 1'b0);
      check("tmo_ready", nec_ready, 1'b1);
      check("tmo_ad",    {nec_ad_oe, nec_ad_out}, {1'b1, 16'hFFFF});
      nec_rdn = 1'b1;
      wait_oe_low();
      check("tmo_trace", trace_data,
            {2'd0, 1'b0, 1'b1, 20'h00100, 2'b01, 6'd0, 16'hFFFF, ts_exp});
      tick();
      check("tvalid_consumed", trace_valid, 1'b0);

      // Trace overflow with consumer stalled
      trace_ready = 1'b0;
      do_read(20'h00010, 1'b1, 1'b0, 16'h1111, 0);
      ts_first = ts_exp;
      nec_rdn  = 1'b1;
      wait_oe_low();
      check("ovf_first_valid", trace_valid, 1'b1);
      check("ovf_not_yet",     trace_overflow, 1'b0);
      do_read(20'h00020, 1'b1, 1'b0, 16'h2222, 1);
      nec_rdn = 1'b1;
      wait_oe_low();
      check("ovf_flag",  trace_overflow, 1'b1);
      check("ovf_held",  trace_data,
            {2'd0, 1'b0, 1'b0, 20'h00010, 2'b11, 6'd0, 16'h1111, ts_first});
      trace_ready = 1'b1;
      tick();
      check("ovf_drained", trace_valid, 1'b0);

      // Reset while waiting in MEM
      astb_phase(20'h2AAAA, 1'b1, 1'b0);
      nec_rdn = 1'b0;
      wait_req();
      reset = 1'b1;
      tick();
      nec_rdn = 1'b1;
      check("mrst_req",   mem_req, 1'b0);
      check("mrst_ready", nec_ready, 1'b1);
      check("mrst_ad",    {nec_ad_oe, nec_ad_out}, {1'b0, 16'h0000});
      check("mrst_sticky", {trace_valid, trace_overflow, timeout_err}, 3'b000);
      reset = 1'b0;
      cyc   = 0;
      mem_rdata = 16'hDEAD;
      mem_ack   = 1'b1;
      tick();
      mem_ack = 1'b0;
      tick();
      check("late_ack_ignored", {mem_req, nec_ready, nec_ad_oe}, 3'b010);
      do_read(20'h00002, 1'b1, 1'b1, 16'h7777, 2);
      check("post_rst_ad", {nec_ad_oe, nec_ad_out}, {1'b1, 16'h7777});
      nec_rdn = 1'b1;
      wait_oe_low();
      check("post_rst_trace", trace_data,
            {2'd0, 1'b0, 1'b0, 20'h00002, 2'b01, 6'd0, 16'h7777, ts_exp});

      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
